// File: rtl/adder_8in.sv
// adder_8in: eight-operand unsigned adder built as a three-stage registered
// binary tree. A valid bit travels alongside the data so o_valid lines up
// with the sum it qualifies.
//
// Handshake: valid-only streaming. The source may present a new operand set
// on any cycle by raising i_valid; there is no ready/stall, so every set
// sampled with i_valid=1 leaves on o_s exactly three rising edges later,
// qualified by o_valid. o_s is meaningful only while o_valid=1.
module adder_8in #(
    parameter int p_width = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [2*p_width-1:0] i_a,
    input  logic [2*p_width-1:0] i_b,
    input  logic [2*p_width-1:0] i_c,
    input  logic [2*p_width-1:0] i_d,
    input  logic [2*p_width-1:0] i_e,
    input  logic [2*p_width-1:0] i_f,
    input  logic [2*p_width-1:0] i_g,
    input  logic [2*p_width-1:0] i_h,
    output logic [2*p_width+2:0] o_s,
    output logic                 o_valid
);

    localparam int OW = 2 * p_width;

    // Each tree level grows by one bit, so no level can overflow.
    logic [OW:0]   s1_ab_d, s1_cd_d, s1_ef_d, s1_gh_d;
    logic [OW:0]   s1_ab_q, s1_cd_q, s1_ef_q, s1_gh_q;
    logic [OW+1:0] s2_abcd_d, s2_efgh_d;
    logic [OW+1:0] s2_abcd_q, s2_efgh_q;
    logic [OW+2:0] s3_d, s3_q;
    logic [2:0]    vld_d, vld_q;

    // Next-state for every level of the tree and the valid shift register.
    always_comb begin
        s1_ab_d   = {1'b0, i_a} + {1'b0, i_b};
        s1_cd_d   = {1'b0, i_c} + {1'b0, i_d};
        s1_ef_d   = {1'b0, i_e} + {1'b0, i_f};
        s1_gh_d   = {1'b0, i_g} + {1'b0, i_h};
        s2_abcd_d = {1'b0, s1_ab_q} + {1'b0, s1_cd_q};
        s2_efgh_d = {1'b0, s1_ef_q} + {1'b0, s1_gh_q};
        s3_d      = {1'b0, s2_abcd_q} + {1'b0, s2_efgh_q};
        vld_d     = {vld_q[1:0], i_valid};
    end

    // Pipeline registers: data advances every cycle; reset clears everything,
    // which also flushes any sets still in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_ab_q   <= '0;
            s1_cd_q   <= '0;
            s1_ef_q   <= '0;
            s1_gh_q   <= '0;
            s2_abcd_q <= '0;
            s2_efgh_q <= '0;
            s3_q      <= '0;
            vld_q     <= '0;
        end else begin
            s1_ab_q   <= s1_ab_d;
            s1_cd_q   <= s1_cd_d;
            s1_ef_q   <= s1_ef_d;
            s1_gh_q   <= s1_gh_d;
            s2_abcd_q <= s2_abcd_d;
            s2_efgh_q <= s2_efgh_d;
            s3_q      <= s3_d;
            vld_q     <= vld_d;
        end
    end

    // Outputs come straight from the last stage registers.
    assign o_s     = s3_q;
    assign o_valid = vld_q[2];

endmodule

// File: tb/tb_adder_8in.sv
// tb_adder_8in: directed and random operand sets for adder_8in. Expected
// sums are queued when a set is driven, tagged with the edge at which the
// result must emerge, and popped by a negedge monitor.
module tb_adder_8in;

    localparam int P  = 6;
    localparam int OW = 2 * P;
    localparam int SW = 2 * P + 3;

    typedef logic [OW-1:0] ops_t [8];

    logic          i_clk;
    logic          i_rst;
    logic          i_valid;
    logic [OW-1:0] i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_h;
    logic [SW-1:0] o_s;
    logic          o_valid;

    logic [SW-1:0] exp_q[$];
    int            due_q[$];
    int            edge_cnt = 0;
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            mon_en   = 0;

    adder_8in #(.p_width(P)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(i_valid),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_c    (i_c),
        .i_d    (i_d),
        .i_e    (i_e),
        .i_f    (i_f),
        .i_g    (i_g),
        .i_h    (i_h),
        .o_s    (o_s),
        .o_valid(o_valid)
    );

    // Clock and edge counter.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] ref_sum(input ops_t ops);
        int acc;
        acc = 0;
        for (int k = 0; k < 8; k++) acc += int'(ops[k]);
        return acc[SW-1:0];
    endfunction

    task automatic put_ops(input ops_t ops);
        i_a = ops[0]; i_b = ops[1]; i_c = ops[2]; i_d = ops[3];
        i_e = ops[4]; i_f = ops[5]; i_g = ops[6]; i_h = ops[7];
    endtask

    function automatic ops_t rand_ops();
        ops_t ops;
        for (int k = 0; k < 8; k++) ops[k] = OW'($urandom_range(0, (1 << OW) - 1));
        return ops;
    endfunction

    function automatic ops_t all_ops(input logic [OW-1:0] v);
        ops_t ops;
        for (int k = 0; k < 8; k++) ops[k] = v;
        return ops;
    endfunction

    // Drive one cycle; a valid set's sum is due after edge (sample edge + 2).
    task automatic send(input ops_t ops, input logic v);
        put_ops(ops);
        i_valid = v;
        if (v) begin
            exp_q.push_back(ref_sum(ops));
            due_q.push_back(edge_cnt + 3);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(rand_ops(), 1'b0);
    endtask

    // Reset with a valid set presented; that set and everything in flight
    // must vanish.
    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            put_ops(rand_ops());
            i_valid = 1'b1;
            i_rst   = 1'b1;
            @(posedge i_clk);
            #1;
            exp_q.delete();
            due_q.delete();
            mon_en = 1;
            check("rst_o_s", 32'(o_s), 32'd0);
            check("rst_o_valid", 32'(o_valid), 32'd0);
        end
        i_rst   = 1'b0;
        i_valid = 1'b0;
    endtask

    // Scoreboard: o_valid must be high exactly when a result is due.
    always @(negedge i_clk) begin
        if (mon_en) begin
            logic exp_v;
            exp_v = (due_q.size() > 0) && (due_q[0] == edge_cnt);
            check("o_valid", 32'(o_valid), 32'(exp_v));
            if (exp_v) begin
                check("o_s", 32'(o_s), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    initial begin
        ops_t ops;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        put_ops(all_ops('0));

        do_reset(2);

        // All zeros.
        send(all_ops(12'h000), 1'b1);
        idle(4);

        // One large operand, seven small: 63 + 7*15 = 168.
        ops = all_ops(12'h00F);
        ops[0] = 12'h03F;
        send(ops, 1'b1);
        idle(4);

        // Back-to-back: 248 then 504 on consecutive cycles.
        send(all_ops(12'h01F), 1'b1);
        send(all_ops(12'h03F), 1'b1);
        idle(4);

        // Mixed operands summing to 167.
        ops[0] = 12'h010; ops[1] = 12'h011; ops[2] = 12'h012; ops[3] = 12'h013;
        ops[4] = 12'h014; ops[5] = 12'h015; ops[6] = 12'h01B; ops[7] = 12'h01D;
        send(ops, 1'b1);
        idle(4);

        // Worst case: 8 * 4095 = 32760 fits without overflow.
        send(all_ops(12'hFFF), 1'b1);
        idle(4);

        // Random traffic with random gaps.
        for (int k = 0; k < 60; k++) send(rand_ops(), logic'($urandom_range(0, 3) != 0));
        idle(4);

        // Flush: three sets then a reset edge. The oldest set's result is
        // already on o_s at the third set's edge; the two behind it are
        // still in the tree and must never produce an o_valid pulse.
        send(rand_ops(), 1'b1);
        send(rand_ops(), 1'b1);
        send(rand_ops(), 1'b1);
        do_reset(1);
        idle(4);

        // First set after reset emerges three edges later.
        send(all_ops(12'h001), 1'b1);
        send(all_ops(12'h800), 1'b1);
        idle(5);

        check("drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
